hazard_unit: RTL and testbench

//  Parametrised hazard unit for the 5-stage pipeline: forwarding select for both EX ALU operands,

---
 rtl/hazard_unit_pkg.sv | 13 +
 rtl/hazard_unit_fwd_select.sv | 31 +++
 rtl/hazard_unit.sv | 131 +++++++++++++
 tb/tb_hazard_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: forwarding select codes and stall FSM states.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        StIdle,
        StStall
    } state_e;

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Forwarding select for one EX ALU operand; the EX/MEM result takes priority over MEM/WB.
module hazard_unit_fwd_select
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    output logic [1:0]       o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hardwired to zero, so a write to it is never forwarded.
    assign w_mem_hit = i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_src);
    assign w_wb_hit  = i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_src);

    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, multi-cycle load-use stall FSM, branch flush and a
// saturating stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic             i_branch_taken,
    input  logic             i_cnt_clr,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_bubble,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned REM_W = $clog2(LOAD_STALL + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hz;
    logic             w_stall;
    logic             w_flush;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    hazard_unit_fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .i_src          (i_ex_rs),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_dst      (i_mem_dst),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_dst       (i_wb_dst),
        .o_sel          (w_fwd_a)
    );

    hazard_unit_fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .i_src          (i_ex_rt),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_dst      (i_mem_dst),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_dst       (i_wb_dst),
        .o_sel          (w_fwd_b)
    );

    assign w_hz = i_ex_memread && (i_ex_dst != '0) &&
                  ((i_ex_dst == i_id_rs) || (i_id_uses_rt && (i_ex_dst == i_id_rt)));

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_branch_taken) begin
                    w_flush = 1'b1;
                end else if (w_hz) begin
                    w_stall = 1'b1;
                    if (LOAD_STALL > 1) begin
                        w_state_next = StStall;
                        w_rem_next   = REM_W'(LOAD_STALL - 1);
                    end
                end
            end
            StStall: begin
                // A taken branch squashes the stalled load-use pair, so the stall is abandoned.
                if (i_branch_taken) begin
                    w_flush      = 1'b1;
                    w_state_next = StIdle;
                    w_rem_next   = '0;
                end else begin
                    w_stall    = 1'b1;
                    w_rem_next = r_rem - REM_W'(1);
                    if (r_rem == REM_W'(1)) begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_rem_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            if (i_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by reset so the safe values appear without waiting for a clock edge.
    assign o_fwd_a       = i_rst_n ? w_fwd_a : FWD_REG;
    assign o_fwd_b       = i_rst_n ? w_fwd_b : FWD_REG;
    assign o_pc_write    = !(i_rst_n && w_stall);
    assign o_ifid_write  = !(i_rst_n && w_stall);
    assign o_idex_bubble = i_rst_n && w_stall;
    assign o_flush       = i_rst_n && w_flush;
    assign o_stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (3-cycle stall/16-bit count, 1-cycle stall/2-bit
// count) share stimulus and are compared against a cycle-level behavioural model.
module tb_hazard_unit;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       pcw;
        logic       ifw;
        logic       bub;
        logic       fl;
    } ctl_t;

    typedef struct {
        ctl_t        a;
        ctl_t        b;
        int unsigned cnt_a;
        int unsigned cnt_b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       id_uses_rt, ex_memread, mem_regwrite, wb_regwrite, branch_taken, cnt_clr;

    logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
    logic        a_pcw, a_ifw, a_bub, a_fl, b_pcw, b_ifw, b_bub, b_fl;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    hazard_unit #(.REG_W(5), .LOAD_STALL(3), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_memread(ex_memread),
        .i_ex_dst(ex_dst), .i_mem_regwrite(mem_regwrite), .i_mem_dst(mem_dst),
        .i_wb_regwrite(wb_regwrite), .i_wb_dst(wb_dst), .i_branch_taken(branch_taken),
        .i_cnt_clr(cnt_clr), .o_fwd_a(a_fwd_a), .o_fwd_b(a_fwd_b), .o_pc_write(a_pcw),
        .o_ifid_write(a_ifw), .o_idex_bubble(a_bub), .o_flush(a_fl), .o_stall_count(a_cnt)
    );

    hazard_unit #(.REG_W(5), .LOAD_STALL(1), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_memread(ex_memread),
        .i_ex_dst(ex_dst), .i_mem_regwrite(mem_regwrite), .i_mem_dst(mem_dst),
        .i_wb_regwrite(wb_regwrite), .i_wb_dst(wb_dst), .i_branch_taken(branch_taken),
        .i_cnt_clr(cnt_clr), .o_fwd_a(b_fwd_a), .o_fwd_b(b_fwd_b), .o_pc_write(b_pcw),
        .o_ifid_write(b_ifw), .o_idex_bubble(b_bub), .o_flush(b_fl), .o_stall_count(b_cnt)
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          left_a = 0;
    int          left_b = 0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (mem_regwrite && mem_dst != 0 && mem_dst == src) return 2'b10;
        if (wb_regwrite && wb_dst != 0 && wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // One pipeline cycle of a unit with stall length l: remaining stall cycles kept as an integer.
    task automatic model_step(input int l, input int unsigned cmax, input logic hz,
                              inout int left, inout int unsigned cnt,
                              output ctl_t c, output int unsigned cnt_now);
        logic stall;
        logic fl;
        if (!rst_n) begin
            left = 0;
            cnt = 0;
            c = '{fa: 2'b00, fb: 2'b00, pcw: 1'b1, ifw: 1'b1, bub: 1'b0, fl: 1'b0};
            cnt_now = 0;
            return;
        end
        cnt_now = cnt;
        stall = 1'b0;
        fl = 1'b0;
        if (branch_taken) begin
            fl = 1'b1;
            left = 0;
        end else if (left > 0) begin
            stall = 1'b1;
            left--;
        end else if (hz) begin
            stall = 1'b1;
            left = l - 1;
        end
        c = '{fa: fwd_model(ex_rs), fb: fwd_model(ex_rt), pcw: !stall, ifw: !stall,
              bub: stall, fl: fl};
        if (cnt_clr) cnt = 0;
        else if (stall && cnt < cmax) cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst} = '0;
        {id_uses_rt, ex_memread, mem_regwrite, wb_regwrite, branch_taken, cnt_clr} = '0;
    endtask

    task automatic commit();
        exp_t e;
        logic hz;
        hz = ex_memread && ex_dst != 0 && (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
        model_step(3, 65535, hz, left_a, cnt_a, e.a, e.cnt_a);
        model_step(1, 3, hz, left_b, cnt_b, e.b, e.cnt_b);
        sb_q.push_back(e);
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_memread = 1'b1;
        ex_dst = r;
        id_rs = r;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("ctl_a", 32'({a_fwd_a, a_fwd_b, a_pcw, a_ifw, a_bub, a_fl}), 32'(e.a));
            check("ctl_b", 32'({b_fwd_a, b_fwd_b, b_pcw, b_ifw, b_bub, b_fl}), 32'(e.b));
            check("count_a", 32'(a_cnt), e.cnt_a);
            check("count_b", 32'(b_cnt), e.cnt_b);
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        tick(); rst_n = 1'b0; commit();
        tick(); idle(); commit();

        // Forwarding priority and register 0.
        tick(); idle(); ex_rs = 3; mem_regwrite = 1; mem_dst = 3; wb_regwrite = 1; wb_dst = 3;
        commit();
        tick(); mem_regwrite = 0; commit();
        tick(); idle(); ex_rt = 0; mem_dst = 0; mem_regwrite = 1; commit();
        tick(); idle(); ex_rt = 7; wb_regwrite = 1; wb_dst = 7; commit();

        // Load-use stall, then rt-only match without id_uses_rt.
        tick(); idle(); load_use(5); commit();
        repeat (4) begin tick(); idle(); commit(); end
        tick(); idle(); ex_memread = 1; ex_dst = 5; id_rs = 1; id_rt = 5; commit();
        tick(); idle(); ex_memread = 1; ex_dst = 5; id_rs = 1; id_rt = 5; id_uses_rt = 1; commit();
        repeat (3) begin tick(); idle(); commit(); end

        // Branch taken in the 2nd stall cycle.
        tick(); idle(); cnt_clr = 1; commit();
        tick(); idle(); load_use(6); commit();
        tick(); idle(); branch_taken = 1; commit();
        repeat (3) begin tick(); idle(); commit(); end

        // Reset in the 2nd stall cycle.
        tick(); idle(); load_use(4); commit();
        tick(); idle(); rst_n = 0; commit();
        tick(); idle(); rst_n = 0; commit();
        repeat (3) begin tick(); idle(); commit(); end

        // Saturation of the 2-bit counter, and clear beating a concurrent stall.
        tick(); idle(); cnt_clr = 1; commit();
        repeat (5) begin tick(); idle(); load_use(2); commit(); end
        tick(); idle(); load_use(2); cnt_clr = 1; commit();
        tick(); idle(); commit();
        tick(); idle(); commit();

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n        = ($urandom_range(0, 149) != 0);
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            ex_rs        = 5'($urandom_range(0, 7));
            ex_rt        = 5'($urandom_range(0, 7));
            ex_dst       = 5'($urandom_range(0, 7));
            mem_dst      = 5'($urandom_range(0, 7));
            wb_dst       = 5'($urandom_range(0, 7));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            cnt_clr      = ($urandom_range(0, 31) == 0);
            commit();
        end

        tick(); idle();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain actual=%0d required=0 entries left", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
